// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID, ID/EX and EX/MEM pipeline registers.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W     = 3,
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned DRAIN_CYCLES   = 3,
  parameter int unsigned R0_HARDWIRED   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  id_halt,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_mem_read,
  input  logic                  ex_rf_write_en,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  pr1_en,
  output logic                  pr1_flush,
  output logic                  pr2_en,
  output logic                  pr2_bubble,
  output logic                  pr3_en,
  output logic                  stall,
  output logic                  halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]           perf_stall_cnt,
  output logic [15:0]           perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [7:0] BP_RELOAD    = 8'(BRANCH_PENALTY - 1);
  localparam logic [7:0] DRAIN_RELOAD = 8'(DRAIN_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  logic w_src1_hit;
  logic w_src2_hit;
  logic w_r0_dest;
  logic w_lu;
  logic w_lu_stall;

  assign w_src1_hit = id_use_src1 && (id_src1 == ex_dest);
  assign w_src2_hit = id_use_src2 && (id_src2 == ex_dest);
  assign w_r0_dest  = (R0_HARDWIRED != 0) && (ex_dest == '0);
  assign w_lu       = ex_mem_read && ex_rf_write_en && (w_src1_hit || w_src2_hit) && !w_r0_dest;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_en       = 1'b1;
    pr1_en      = 1'b1;
    pr1_flush   = 1'b0;
    pr2_en      = 1'b1;
    pr2_bubble  = 1'b0;
    pr3_en      = 1'b1;
    stall       = 1'b0;
    halted      = (r_state == HALTED);
    w_lu_stall  = 1'b0;

    if (mem_busy) begin
      pc_en  = 1'b0;
      pr1_en = 1'b0;
      pr2_en = 1'b0;
      pr3_en = 1'b0;
      stall  = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (branch_taken) begin
            pr1_flush = 1'b1;
            stall     = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              w_state_nxt = FLUSH;
              w_cnt_nxt   = BP_RELOAD;
            end
          end else if (w_lu) begin
            pc_en      = 1'b0;
            pr1_en     = 1'b0;
            pr2_bubble = 1'b1;
            stall      = 1'b1;
            w_lu_stall = 1'b1;
          end else if (id_halt) begin
            pc_en       = 1'b0;
            pr1_flush   = 1'b1;
            pr2_bubble  = 1'b1;
            stall       = 1'b1;
            w_state_nxt = DRAIN;
            w_cnt_nxt   = DRAIN_RELOAD;
          end
        end
        FLUSH: begin
          pr1_flush = 1'b1;
          stall     = 1'b1;
          // Exit on the cycle the decrement reaches zero, so the window spans BRANCH_PENALTY cycles.
          if (branch_taken) begin
            w_cnt_nxt = BP_RELOAD;
          end else if (r_cnt <= 8'd1) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        DRAIN: begin
          pc_en      = 1'b0;
          pr1_flush  = 1'b1;
          pr2_bubble = 1'b1;
          stall      = 1'b1;
          if (r_cnt <= 8'd1) begin
            w_state_nxt = HALTED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
        HALTED: begin
          pc_en      = 1'b0;
          pr1_flush  = 1'b1;
          pr2_bubble = 1'b1;
          stall      = 1'b1;
        end
        default: begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] r_perf_stall;
  logic [15:0] r_perf_flush;
  logic        w_stall_evt;
  logic        w_flush_evt;

  assign w_stall_evt = mem_busy || w_lu_stall;
  assign w_flush_evt = pr1_flush && (r_state != DRAIN) && (r_state != HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_stall_evt && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 16'd1;
      if (w_flush_evt && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline registers (IF/ID = PR1, ID/EX = PR2, EX/MEM = PR3).
- Detects load-use hazards, data-memory wait, taken branches and HALT.
- Drives per-stage enable, flush and bubble controls, and handles the end-of-program drain into a halted state.
- Sits beside the decoder and consumes ID-stage register addresses plus EX/MEM-stage status.

Parameters:
- REG_ADDR_W, 3, width of register-file addresses.
- BRANCH_PENALTY, 2, cycles of IF/ID squash after a taken branch (>=1).
- DRAIN_CYCLES, 3, cycles allowed for in-flight instructions to retire after HALT (>=1).
- R0_HARDWIRED, 1, when 1 a destination of register 0 never causes a hazard.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_src1  in  REG_ADDR_W  source reg 1 of instruction in ID.
- id_src2  in  REG_ADDR_W  source reg 2 of instruction in ID.
- id_use_src1  in  1  ID instruction reads src1.
- id_use_src2  in  1  ID instruction reads src2.
- id_halt  in  1  ID instruction is HALT.
- ex_dest  in  REG_ADDR_W  destination reg of instruction in EX (PR2 output).
- ex_mem_read  in  1  EX instruction is a load.
- ex_rf_write_en  in  1  EX instruction writes the register file.
- branch_taken  in  1  branch resolved taken this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze.
- pc_en  out  1  PC load enable.
- pr1_en  out  1  IF/ID load enable.
- pr1_flush  out  1  IF/ID loads NOP instead of fetched data.
- pr2_en  out  1  ID/EX load enable.
- pr2_bubble  out  1  ID/EX loads all-zero control signals (NOP).
- pr3_en  out  1  EX/MEM load enable.
- stall  out  1  status: any stall, flush or freeze active this cycle.
- halted  out  1  pipeline halted.

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high (the polarity and synchronicity are fixed).
- Registered state: `state` (RUN, FLUSH, DRAIN, HALTED) and an 8-bit down-counter `cnt`. Outputs are combinational from state and inputs.
- Reset: on a clk edge with rst=1, state=RUN and cnt=0. In RUN with no events the outputs are pc_en=pr1_en=pr2_en=pr3_en=1, pr1_flush=pr2_bubble=stall=halted=0.
- Load-use hazard (`lu`): ex_mem_read & ex_rf_write_en & ((id_use_src1 & id_src1==ex_dest) | (id_use_src2 & id_src2==ex_dest)), suppressed when R0_HARDWIRED and ex_dest==0.
- Per-cycle priority: mem_busy > branch_taken > lu > id_halt.
- mem_busy=1, any state: pc_en=pr1_en=pr2_en=pr3_en=0, pr1_flush=pr2_bubble=0, stall=1. State and cnt hold.
- RUN:
  - branch_taken: pr1_flush=1, stall=1. If BRANCH_PENALTY>1, go to FLUSH with cnt=BRANCH_PENALTY-1; otherwise stay in RUN.
  - lu (no branch): pc_en=0, pr1_en=0, pr2_bubble=1, stall=1. Stay in RUN. Exactly one bubble per hazard, because the load advances next cycle.
  - id_halt (no higher event): pc_en=0, pr1_flush=1, pr2_bubble=1, stall=1. Go to DRAIN with cnt=DRAIN_CYCLES-1.
- FLUSH: pr1_flush=1, stall=1, other enables 1. cnt decrements; go to RUN in the cycle cnt==0. branch_taken in FLUSH restarts the window: cnt=BRANCH_PENALTY-1. lu and id_halt are ignored (ID holds a squashed NOP).
- DRAIN: pc_en=0, pr1_flush=1, pr2_bubble=1, pr2_en=pr3_en=1, stall=1. cnt decrements; go to HALTED when cnt==0. branch_taken, lu and id_halt are ignored.
- HALTED: same outputs as DRAIN, plus halted=1. Exit only via rst.
- rst mid-FLUSH or mid-DRAIN returns to RUN next edge; no residual flush.
- Simultaneous branch_taken and lu: branch wins and no bubble is inserted, since the squashed ID instruction needs none.

Optional Feature:
- PIPE_PERF_CNT_EN defined: adds outputs perf_stall_cnt[15:0] and perf_flush_cnt[15:0].
  - perf_stall_cnt increments in cycles with mem_busy or lu stall.
  - perf_flush_cnt increments in cycles with pr1_flush=1 while state != DRAIN/HALTED.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the counter ports and logic are absent.

Test Plan:
- Load-use: ex_mem_read=1, ex_rf_write_en=1, ex_dest=3, id_use_src1=1, id_src1=3 for 1 cycle -> pc_en=0, pr1_en=0, pr2_bubble=1 that cycle; all enables 1 next cycle with ex_mem_read=0.
- R0 filter: same as above with ex_dest=0, id_src1=0 -> no stall, pc_en=1.
- Branch penalty: branch_taken pulsed 1 cycle, BRANCH_PENALTY=2 -> pr1_flush=1 for exactly 2 consecutive cycles, then RUN.
- Freeze priority: mem_busy=1 for 3 cycles during FLUSH with cnt=1 -> all enables 0 for 3 cycles, cnt holds; one more flush cycle after mem_busy drops.
- Halt: id_halt=1, DRAIN_CYCLES=3 -> stall for 3 cycles, halted=1 from the 4th cycle and it persists with branch_taken=1 applied; rst=1 for 1 edge -> halted=0, all enables 1.
- Branch plus load-use together: branch_taken=1 and lu conditions true in the same cycle -> pr1_flush=1, pr2_bubble=0, pc_en=1.
